// File: rtl/real_conv_pkg.sv
// Shared types and the clamp helper for the real/int conversion arbiter.
// Fixed-point codes are value = code * 2^REAL_EXP; integers are plain two's complement.
package real_conv_pkg;

  typedef enum logic {
    REAL_TO_INT = 1'b0,
    INT_TO_REAL = 1'b1
  } conv_dir_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam int SAT_W = 64;

  // Clamp a wide signed value into a width-bit signed range, flagging when it clipped.
  function automatic logic signed [SAT_W-1:0] satClamp(
    input  logic signed [SAT_W-1:0] value,
    input  int                      width,
    output logic                    clamped
  );
    logic signed [SAT_W-1:0] maxV;
    logic signed [SAT_W-1:0] minV;
    maxV     = (64'sd1 <<< (width - 1)) - 64'sd1;
    minV     = -maxV - 64'sd1;
    clamped  = 1'b0;
    satClamp = value;
    if (value > maxV) begin
      satClamp = maxV;
      clamped  = 1'b1;
    end else if (value < minV) begin
      satClamp = minV;
      clamped  = 1'b1;
    end
  endfunction

endpackage

// File: rtl/real_conv_pipe.sv
// Two-stage shift/saturate conversion pipeline with its own stall logic.
// The requester ID rides alongside the data so the response can be tagged.
module real_conv_pipe
  import real_conv_pkg::*;
#(
  parameter int REAL_WIDTH = 18,
  parameter int REAL_EXP   = -8,
  parameter int INT_WIDTH  = 8,
  parameter int ID_W       = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inValid_i,
  input  conv_dir_t             inDir_i,
  input  logic [REAL_WIDTH-1:0] inData_i,
  input  logic [ID_W-1:0]       inId_i,
  output logic                  inReady_o,
  output logic                  outValid_o,
  input  logic                  outReady_i,
  output logic [ID_W-1:0]       outId_o,
  output logic [REAL_WIDTH-1:0] outData_o,
  output logic                  outSat_o,
  output logic                  busy_o
);

  localparam int S  = -REAL_EXP;
  localparam int WW = REAL_WIDTH + S + 1;

  logic signed [REAL_WIDTH-1:0] realIn;
  logic signed [INT_WIDTH-1:0]  intIn;
  logic signed [WW-1:0]         s1Val_d, s1Val_q;
  logic                         s1Valid_q, s2Valid_q;
  conv_dir_t                    s1Dir_q;
  logic [ID_W-1:0]              s1Id_q, s2Id_q;
  logic [REAL_WIDTH-1:0]        s2Data_d, s2Data_q;
  logic                         s2Sat_d, s2Sat_q;
  logic                         load2, adv1;
  int                           satW;

  assign realIn = inData_i;
  assign intIn  = inData_i[INT_WIDTH-1:0];
  // Widen before shifting so the int->real left shift cannot lose bits before clamping.
  assign s1Val_d = (inDir_i == INT_TO_REAL) ? (WW'(intIn) <<< S) : (WW'(realIn) >>> S);

  assign load2     = !s2Valid_q || outReady_i;
  assign adv1      = load2 || !s1Valid_q;
  assign inReady_o = adv1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q <= 1'b0;
      s1Dir_q   <= REAL_TO_INT;
      s1Val_q   <= '0;
      s1Id_q    <= '0;
    end else if (adv1) begin
      s1Valid_q <= inValid_i;
      s1Dir_q   <= inDir_i;
      s1Val_q   <= s1Val_d;
      s1Id_q    <= inId_i;
    end
  end

  always_comb begin
    s2Sat_d  = 1'b0;
    satW     = (s1Dir_q == INT_TO_REAL) ? REAL_WIDTH : INT_WIDTH;
    s2Data_d = REAL_WIDTH'(satClamp(64'(s1Val_q), satW, s2Sat_d));
  end

  // Payload only moves on a real item, so a bubble leaves the last response visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2Valid_q <= 1'b0;
      s2Id_q    <= '0;
      s2Data_q  <= '0;
      s2Sat_q   <= 1'b0;
    end else if (load2) begin
      s2Valid_q <= s1Valid_q;
      if (s1Valid_q) begin
        s2Id_q   <= s1Id_q;
        s2Data_q <= s2Data_d;
        s2Sat_q  <= s2Sat_d;
      end
    end
  end

  assign outValid_o = s2Valid_q;
  assign outId_o    = s2Id_q;
  assign outData_o  = s2Data_q;
  assign outSat_o   = s2Sat_q;
  assign busy_o     = s1Valid_q || s2Valid_q;

endmodule

// File: rtl/real_conv_arbiter.sv
// Round-robin front end that shares one real_conv_pipe between N_REQ requesters.
// Grants are combinational; the pointer moves only on an accepted transfer.
module real_conv_arbiter
  import real_conv_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int REAL_WIDTH = 18,
  parameter int REAL_EXP   = -8,
  parameter int INT_WIDTH  = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic [N_REQ-1:0]                 req_valid,
  output logic [N_REQ-1:0]                 req_ready,
  input  logic [N_REQ-1:0]                 req_dir,
  input  logic [N_REQ-1:0][REAL_WIDTH-1:0] req_data,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [$clog2(N_REQ)-1:0]         rsp_id,
  output logic [REAL_WIDTH-1:0]            rsp_data,
  output logic                             rsp_sat,
  output logic                             busy
);

  localparam int ID_W = $clog2(N_REQ);

  arb_state_t      state_q, state_d;
  logic [ID_W-1:0] last_q, grantIdx, idx;
  logic            found, pipeReady, pipeBusy, grantOk, grantFire;

  // Scan last+1, last+2, ... and take the first valid requester.
  always_comb begin
    found    = 1'b0;
    grantIdx = '0;
    idx      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ID_W'((int'(last_q) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        grantIdx = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grantOk = en && pipeReady && (state_q != DRAIN);
    unique case (state_q)
      IDLE:    if (en && (|req_valid)) state_d = RUN;
      RUN: begin
        if (!en)                             state_d = DRAIN;
        else if (!(|req_valid) && !pipeBusy) state_d = IDLE;
      end
      DRAIN: begin
        if (en)             state_d = RUN;
        else if (!pipeBusy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign grantFire = grantOk && found;
  assign req_ready = grantFire ? (N_REQ'(1) << grantIdx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= ID_W'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      if (grantFire) last_q <= grantIdx;
    end
  end

  real_conv_pipe #(
    .REAL_WIDTH(REAL_WIDTH),
    .REAL_EXP  (REAL_EXP),
    .INT_WIDTH (INT_WIDTH),
    .ID_W      (ID_W)
  ) uPipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .inValid_i (grantFire),
    .inDir_i   (conv_dir_t'(req_dir[grantIdx])),
    .inData_i  (req_data[grantIdx]),
    .inId_i    (grantIdx),
    .inReady_o (pipeReady),
    .outValid_o(rsp_valid),
    .outReady_i(rsp_ready),
    .outId_o   (rsp_id),
    .outData_o (rsp_data),
    .outSat_o  (rsp_sat),
    .busy_o    (pipeBusy)
  );

  assign busy = pipeBusy;

endmodule
